collision_events: RTL and testbench

Frame-level collision event generator sitting between the per-pixel draw flags and the game-state counters (score accumulator, lives counter). It samples same-cycle coincidences of the ship, torpedo and asteroid draw flags across a whole video frame, then emits clean single-cycle events at the next frame start. It also runs the post-death invulnerability state machine, so downstream counters see at most one `die` and one `hit` per frame.

---
 rtl/asteroids_pkg.sv | 22 ++
 rtl/collision_events_if.sv | 36 +++
 rtl/collision_events_frame_countdown.sv | 46 ++++
 rtl/collision_events.sv | 138 +++++++++++++
 tb/tb_collision_events.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/asteroids_pkg.sv
// ============================================================================
// Module  : asteroids_pkg
// Brief   : Shared constants and types for the collision/event datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package asteroids_pkg;

   localparam int T_NUM        = 4;
   localparam int GRACE_FRAMES = 120;
   localparam int GRACE_W      = 10;

   typedef enum logic [1:0] {
      ARMED = 2'd0,
      GRACE = 2'd1,
      HALT  = 2'd2
   } coll_state_t;

endpackage

`default_nettype wire

// File: rtl/collision_events_if.sv
// ============================================================================
// Module  : collision_events_if
// Brief   : Draw-flag inputs and frame-event outputs of collision_events.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface collision_events_if #(
   parameter int T_NUM = asteroids_pkg::T_NUM
);
   localparam int CNT_W = $clog2(T_NUM + 1);

   logic             frame_start;
   logic             game_over;
   logic             draw_ship;
   logic             draw_asteroid;
   logic [T_NUM-1:0] draw_torpedo;
   logic             die;
   logic             hit;
   logic [T_NUM-1:0] hit_mask;
   logic [CNT_W-1:0] hit_count;
   logic             invulnerable;

   modport master (
      output frame_start, game_over, draw_ship, draw_asteroid, draw_torpedo,
      input  die, hit, hit_mask, hit_count, invulnerable
   );

   modport slave (
      input  frame_start, game_over, draw_ship, draw_asteroid, draw_torpedo,
      output die, hit, hit_mask, hit_count, invulnerable
   );

endinterface

`default_nettype wire

// File: rtl/collision_events_frame_countdown.sv
// ============================================================================
// Module  : frame_countdown
// Brief   : Loadable frame down-counter; expire pulses on an enabled count of 1.
//           Only present when COLLISION_GRACE_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef COLLISION_GRACE_EN
module frame_countdown #(
   parameter int LOAD_VALUE = asteroids_pkg::GRACE_FRAMES,
   parameter int WIDTH      = asteroids_pkg::GRACE_W
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic expire
);
   import asteroids_pkg::*;

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = WIDTH'(LOAD_VALUE);
      end else if (en && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= WIDTH'(LOAD_VALUE);
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = en & (count_q == WIDTH'(1));

endmodule
`endif

`default_nettype wire

// File: rtl/collision_events.sv
// ============================================================================
// Module  : collision_events
// Brief   : Frame-level collision flags -> single-cycle die/hit events, with
//           post-death invulnerability (enabled by COLLISION_GRACE_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_events #(
   parameter int T_NUM        = asteroids_pkg::T_NUM,
   parameter int GRACE_FRAMES = asteroids_pkg::GRACE_FRAMES
) (
   input  logic               clk,
   input  logic               reset,
   collision_events_if.slave  bus
);
   import asteroids_pkg::*;

   localparam int         CNT_W    = $clog2(T_NUM + 1);
   localparam logic [1:0] ST_ARMED = ARMED;
   localparam logic [1:0] ST_HALT  = HALT;
`ifdef COLLISION_GRACE_EN
   localparam logic [1:0] ST_GRACE = GRACE;
   localparam logic [1:0] ST_RESET = ST_GRACE;
`else
   localparam logic [1:0] ST_RESET = ST_ARMED;
`endif

   logic [1:0]       state_q, state_d;
   logic             ship_f_q, ship_f_d;
   logic [T_NUM-1:0] torp_f_q, torp_f_d;
   logic             die_q, die_d;
   logic             hit_q, hit_d;
   logic [T_NUM-1:0] hit_mask_q, hit_mask_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;

`ifdef COLLISION_GRACE_EN
   logic cd_load;
   logic cd_en;
   logic cd_expire;

   frame_countdown #(
      .LOAD_VALUE (GRACE_FRAMES),
      .WIDTH      (GRACE_W)
   ) u_frame_countdown (
      .clk    (clk),
      .reset  (reset),
      .load   (cd_load),
      .en     (cd_en),
      .expire (cd_expire)
   );
`else
   logic unused_grace_frames;
   assign unused_grace_frames = (GRACE_FRAMES > 0);
`endif

   always_comb begin
      // A coincidence on the boundary cycle belongs to the new frame: clear, then set.
      ship_f_d    = (ship_f_q & ~bus.frame_start) | (bus.draw_ship & bus.draw_asteroid);
      torp_f_d    = (torp_f_q & {T_NUM{~bus.frame_start}})
                  | (bus.draw_torpedo & {T_NUM{bus.draw_asteroid}});
      state_d     = state_q;
      die_d       = 1'b0;
      hit_mask_d  = '0;
`ifdef COLLISION_GRACE_EN
      cd_load     = 1'b0;
      cd_en       = 1'b0;
`endif
      if (bus.frame_start) begin
         if (bus.game_over) begin
            state_d = ST_HALT;
         end else begin
            case (state_q)
               ST_ARMED: begin
                  die_d      = ship_f_q;
                  hit_mask_d = torp_f_q;
`ifdef COLLISION_GRACE_EN
                  if (ship_f_q) begin
                     state_d = ST_GRACE;
                     cd_load = 1'b1;
                  end
`endif
               end
`ifdef COLLISION_GRACE_EN
               ST_GRACE: begin
                  hit_mask_d = torp_f_q;
                  cd_en      = 1'b1;
                  if (cd_expire) begin
                     state_d = ST_ARMED;
                  end
               end
`endif
               default: begin
                  state_d = state_q;
               end
            endcase
         end
      end
      hit_d       = |hit_mask_d;
      hit_count_d = '0;
      for (int i = 0; i < T_NUM; i++) begin
         hit_count_d = hit_count_d + CNT_W'(hit_mask_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RESET;
         ship_f_q    <= 1'b0;
         torp_f_q    <= '0;
         die_q       <= 1'b0;
         hit_q       <= 1'b0;
         hit_mask_q  <= '0;
         hit_count_q <= '0;
      end else begin
         state_q     <= state_d;
         ship_f_q    <= ship_f_d;
         torp_f_q    <= torp_f_d;
         die_q       <= die_d;
         hit_q       <= hit_d;
         hit_mask_q  <= hit_mask_d;
         hit_count_q <= hit_count_d;
      end
   end

   assign bus.die       = die_q;
   assign bus.hit       = hit_q;
   assign bus.hit_mask  = hit_mask_q;
   assign bus.hit_count = hit_count_q;
`ifdef COLLISION_GRACE_EN
   assign bus.invulnerable = (state_q == ST_GRACE);
`else
   assign bus.invulnerable = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_collision_events.sv
// ============================================================================
// Module  : tb_collision_events
// Brief   : Cycle-vector bench for collision_events (either COLLISION_GRACE_EN build).
// Revision: 1.1 - added reset-state and watchdog checks
// ============================================================================
`default_nettype none

module tb_collision_events;

`ifdef COLLISION_GRACE_EN
    localparam bit c_G = 1'b1;
`else
    localparam bit c_G = 1'b0;
`endif

    localparam int c_TIMEOUT_NS = 10_000_000;

    typedef struct {
        bit         rst;
        bit         fs;
        bit         go;
        bit         sh;
        bit         as;
        logic [3:0] tp;
        bit         e_die;
        bit         e_hit;
        logic [3:0] e_mask;
        logic [2:0] e_cnt;
        bit         e_inv;
    } vec_t;

    logic clk = 1'b0;
    logic r_rst;
    logic r_done = 1'b0;
    vec_t r_vq[$];
    int   r_n_vec = 0;
    int   r_n_bad = 0;

    collision_events_if #(.T_NUM(4)) bus ();

    collision_events #(
        .T_NUM        (4),
        .GRACE_FRAMES (120)
    ) dut (
        .clk   (clk),
        .reset (r_rst),
        .bus   (bus)
    );

    always #20 clk = ~clk;

    task automatic add(input bit rst, input bit fs, input bit go, input bit sh, input bit as,
                       input logic [3:0] tp, input bit e_die, input bit e_hit,
                       input logic [3:0] e_mask, input logic [2:0] e_cnt, input bit e_inv);
        vec_t v;
        v.rst = rst; v.fs = fs; v.go = go; v.sh = sh; v.as = as; v.tp = tp;
        v.e_die = e_die; v.e_hit = e_hit; v.e_mask = e_mask; v.e_cnt = e_cnt; v.e_inv = e_inv;
        r_vq.push_back(v);
    endtask

    task automatic chk_vec(input int idx, input vec_t v);
        if (bus.die !== v.e_die || bus.hit !== v.e_hit ||
            bus.hit_mask !== v.e_mask || bus.hit_count !== v.e_cnt ||
            bus.invulnerable !== v.e_inv) begin
            r_n_bad++;
            $display("FAIL vec%0d die/hit/mask/cnt/inv got %b/%b/%b/%0d/%b exp %b/%b/%b/%0d/%b",
                     idx, bus.die, bus.hit, bus.hit_mask, bus.hit_count, bus.invulnerable,
                     v.e_die, v.e_hit, v.e_mask, v.e_cnt, v.e_inv);
        end
    endtask

    task automatic to_armed();
        if (c_G) begin
            for (int f = 1; f <= 120; f++) begin
                add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, 1'b1);
                add(0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, (f < 120));
            end
        end
    endtask

    initial begin
        #(c_TIMEOUT_NS);
        if (!r_done) begin
            r_n_bad++;
            $display("FAIL timeout: vector stream not finished after %0d ns (%0d vectors applied)",
                     c_TIMEOUT_NS, r_n_vec);
            $finish;
        end
    end

    initial begin
        r_rst             = 1'b1;
        bus.frame_start   = 1'b0;
        bus.game_over     = 1'b0;
        bus.draw_ship     = 1'b0;
        bus.draw_asteroid = 1'b0;
        bus.draw_torpedo  = 4'b0000;
        @(posedge clk);
        #1;
        if (bus.die !== 1'b0 || bus.hit !== 1'b0 || bus.hit_mask !== 4'b0000 ||
            bus.hit_count !== 3'd0 || bus.invulnerable !== c_G) begin
            r_n_bad++;
            $display("FAIL reset state die/hit/mask/cnt/inv got %b/%b/%b/%0d/%b exp 0/0/0000/0/%b",
                     bus.die, bus.hit, bus.hit_mask, bus.hit_count, bus.invulnerable, c_G);
        end

        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, c_G);
        if (c_G) begin
            for (int f = 1; f <= 121; f++) begin
                add(0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000, 3'd0, (f <= 120));
                add(0, 1, 0, 0, 0, 4'b0000, (f == 121), 0, 4'b0000, 3'd0, (f < 120) || (f == 121));
            end
            to_armed();
        end else begin
            for (int f = 1; f <= 3; f++) begin
                add(0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000, 3'd0, 1'b0);
                add(0, 1, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 3'd0, 1'b0);
            end
        end
        add(0, 0, 0, 0, 1, 4'b0001, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 0, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 0, 0, 0, 1, 4'b0100, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 0, 0, 0, 0, 4'b1000, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 1, 0, 0, 0, 4'b0000, 0, 1, 4'b0101, 3'd2, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 1, 0, 1, 1, 4'b1010, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 1, 0, 0, 0, 4'b0000, 1, 1, 4'b1010, 3'd2, c_G);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, c_G);
        to_armed();
        add(0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 0, 0, 0, 1, 4'b0010, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, 0);
        for (int f = 1; f <= 10; f++) begin
            add(0, 0, 0, 1, 1, 4'b1111, 0, 0, 4'b0000, 3'd0, 0);
            add(0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, 0);
        end
        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, c_G);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, c_G);
        add(0, 0, 0, 1, 1, 4'b0001, 0, 0, 4'b0000, 3'd0, c_G);
        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, c_G);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, c_G);
        add(0, 1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, c_G);
        add(0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b0000, 3'd0, c_G);
        add(0, 1, 0, 0, 0, 4'b0000, 0, 1, 4'b1111, 3'd4, c_G);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 3'd0, c_G);

        foreach (r_vq[i]) begin
            r_rst             = r_vq[i].rst;
            bus.frame_start   = r_vq[i].fs;
            bus.game_over     = r_vq[i].go;
            bus.draw_ship     = r_vq[i].sh;
            bus.draw_asteroid = r_vq[i].as;
            bus.draw_torpedo  = r_vq[i].tp;
            @(posedge clk);
            #1;
            r_n_vec++;
            chk_vec(i, r_vq[i]);
        end

        r_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_bad);
        $finish;
    end

endmodule

`default_nettype wire
